// File: rtl/sram_like_pkg.sv
// Shared types, constants and the byte-lane helper for the SRAM-like slave memory.
package sram_like_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    typedef struct packed {
        logic        is_write;
        logic [31:0] data;
        logic [3:0]  age;
    } resp_entry_t;

    localparam logic [31:0] MISALIGN_DATA = 32'hDEADBEEF;

    // The unnamed encoding 3 falls into the default branch and behaves as a word.
    function automatic logic [3:0] byte_enable(input size_t size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: each entry ages once per cycle (saturating at LATENCY).
// The head retires only once it has reached that age.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int LATENCY         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_is_write,
    input  logic [31:0] i_data,
    output logic        o_retire,
    output resp_entry_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [3:0]       AGE_MAX  = 4'(LATENCY);

    resp_entry_t      r_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign o_head   = r_mem[r_head];
    assign w_retire = !rst && (r_count != '0) && (r_mem[r_head].age == AGE_MAX);
    assign o_retire = w_retire;
    assign o_full   = (r_count == CNT_MAX);
    assign o_empty  = (r_count == '0);

    // Slots outside the live window also age, harmlessly: a push rewrites the age.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (r_mem[i].age < AGE_MAX) begin
                    r_mem[i].age <= r_mem[i].age + 4'd1;
                end
            end
            if (i_push) begin
                r_mem[r_tail] <= '{is_write: i_is_write, data: i_data, age: 4'd1};
                r_tail        <= next_ptr(r_tail);
            end
            if (w_retire) begin
                r_head <= next_ptr(r_head);
            end
            case ({i_push, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_mem.sv
// SRAM-like slave memory with configurable latency, outstanding depth and addr_ok stalls.
// Define SRAM_LIKE_MEM_ALIGN_CHECK_EN to add the sticky misalignment flag err.
module sram_like_mem
    import sram_like_pkg::*;
#(
    parameter int ADDR_WIDTH      = 12,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2,
    parameter int STALL_PERIOD    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

    logic [31:0] ram [DEPTH];

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_be;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_wr_en;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_push_data;
    logic                  w_stall_now;
    logic                  w_retire;
    logic                  w_full;
    logic                  w_empty;
    resp_entry_t           w_head;
    logic [STALL_W-1:0]    r_stall_cnt;
    logic                  w_unused;

    assign w_idx    = addr[ADDR_WIDTH+1:2];
    assign w_be     = byte_enable(size_t'(size), addr[1:0]);
    assign w_accept = req && addr_ok;

`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
    assign w_misalign = (size == 2'd1 && addr[0]) ||
                        (size == 2'd2 && addr[1:0] != 2'b00) ||
                        (size == 2'd3);
`else
    assign w_misalign = 1'b0;
`endif

    // Reads capture the word at acceptance, so ordering against writes is fixed here.
    assign w_wr_en     = w_accept && wr && !w_misalign;
    assign w_rd_word   = w_misalign ? MISALIGN_DATA : ram[w_idx];
    assign w_push_data = wr ? 32'h0 : w_rd_word;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    ram[w_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (STALL_PERIOD != 0) begin
            r_stall_cnt <= (r_stall_cnt == STALL_LAST) ? '0 : r_stall_cnt + 1'b1;
        end
    end

    assign w_stall_now = (STALL_PERIOD != 0) && (r_stall_cnt == STALL_LAST);

    sram_like_resp_fifo #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .LATENCY         (LATENCY)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_accept),
        .i_is_write (wr),
        .i_data     (w_push_data),
        .o_retire   (w_retire),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // A retiring head frees its slot in time for a same-cycle acceptance.
    assign addr_ok = !rst && !w_stall_now && (!w_full || w_retire);
    assign data_ok = w_retire;
    assign rdata   = w_retire ? w_head.data : 32'h0;

`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (w_accept && w_misalign) begin
            err <= 1'b1;
        end
    end
`endif

    assign w_unused = ^{addr[31:ADDR_WIDTH+2], w_head.age, w_empty};

endmodule

// File: tb/tb_sram_like_mem.sv
// Scoreboard bench for sram_like_mem: directed and random requests against a transaction model.
// Build with SRAM_LIKE_MEM_ALIGN_CHECK_EN defined to also cover the err flag.
module tb_sram_like_mem;

    localparam int AW    = 6;
    localparam int LAT   = 3;
    localparam int MAXO  = 2;
    localparam int STALL = 4;
    localparam int DEPTH = 1 << AW;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic [1:0]  size  = 2'd0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;
`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
    logic        err;
`endif

    sram_like_mem #(
        .ADDR_WIDTH      (AW),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO),
        .STALL_PERIOD    (STALL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .addr_ok (addr_ok),
        .data_ok (data_ok)
`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
        ,
        .err     (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    logic [31:0] model [DEPTH];
    int          cyc       = 0;
    int          nChecks   = 0;
    int          nErrors   = 0;
    int          errSetCyc = -1;

    // Cycle index restarts at 0 in the first cycle after reset is released.
    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nErrors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic logic stallNow(input int c);
        return (STALL != 0) && ((c % STALL) == STALL - 1);
    endfunction

    // Evaluated after the monitor has retired this cycle's head, so a free slot covers both cases.
    function automatic logic okExp();
        return !stallNow(cyc) && (expQ.size() < MAXO);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            checkOutput("rst_data_ok", {31'h0, data_ok}, 32'h0);
            checkOutput("rst_addr_ok", {31'h0, addr_ok}, 32'h0);
            checkOutput("rst_rdata", rdata, 32'h0);
            expQ.delete();
            errSetCyc = -1;
        end else begin
            if (data_ok) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nErrors++;
                    $display("[TB] FAIL unexpected_data_ok at cycle %0d: got 1, expected 0", cyc);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("rdata", rdata, monE.data);
                    checkOutput("retire_cycle", cyc, monE.due);
                end
            end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL missing_data_ok at cycle %0d: got 0, expected 1 (due %0d)", cyc, expQ[0].due);
                void'(expQ.pop_front());
            end
            checkOutput("addr_ok", {31'h0, addr_ok}, {31'h0, okExp()});
`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
            checkOutput("err", {31'h0, err}, {31'h0, (errSetCyc >= 0 && cyc > errSetCyc)});
`endif
        end
    end

    // Reference model of one accepted request, expressed as lane ranges rather than masks.
    task automatic modelAccept();
        int          idx;
        int          nBytes;
        int          first;
        int          due;
        logic        misal;
        logic [31:0] data;
        exp_t        e;
        idx   = int'(addr[AW+1:2]);
        misal = 1'b0;
`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
        misal = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00) || (size == 2'd3);
`endif
        nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        first  = (size == 2'd0) ? int'(addr[1:0]) : (size == 2'd1) ? (addr[1] ? 2 : 0) : 0;
        if (wr) begin
            data = 32'h0;
            if (!misal) begin
                for (int b = first; b < first + nBytes; b++) begin
                    model[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else begin
            data = misal ? 32'hDEADBEEF : model[idx];
        end
        if (misal && errSetCyc < 0) errSetCyc = cyc;
        due = cyc + LAT;
        if (expQ.size() != 0 && expQ[$].due + 1 > due) due = expQ[$].due + 1;
        e.data = data;
        e.due  = due;
        expQ.push_back(e);
    endtask

    // Holds the request until the model says it is accepted, then returns at the next cycle start.
    task automatic applyStimulus(input logic iWr, input logic [1:0] iSize,
                                 input logic [31:0] iAddr, input logic [31:0] iData);
        req   = 1'b1;
        wr    = iWr;
        size  = iSize;
        addr  = iAddr;
        wdata = iData;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (okExp()) begin
                modelAccept();
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        nChecks++;
        nErrors++;
        $display("[TB] FAIL accept_timeout addr %h: got no acceptance, expected one within 40 cycles", iAddr);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected one before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'd2, 32'(i * 4), $urandom);
        idle(6);

        applyStimulus(1'b1, 2'd2, 32'h10, 32'h11223344);
        idle(4);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0);
        idle(6);

        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h4, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h8, 32'h0);
        idle(8);

        applyStimulus(1'b1, 2'd2, 32'h0, 32'h0);
        applyStimulus(1'b1, 2'd0, 32'h3, 32'hAB000000);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0);
        idle(6);
        checkOutput("ram0_byte", dut.ram[0], 32'hAB000000);
        applyStimulus(1'b1, 2'd1, 32'h2, 32'h12340000);
        applyStimulus(1'b0, 2'd2, 32'h0, 32'h0);
        idle(6);
        checkOutput("ram0_half", dut.ram[0], 32'h12340000);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(8);

        applyStimulus(1'b1, 2'd2, 32'h24, 32'hCAFEF00D);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'h24, 32'h0);
        doReset(2);
        idle(10);
        checkOutput("ram_retained", dut.ram[9], 32'hCAFEF00D);
        applyStimulus(1'b0, 2'd2, 32'h24, 32'h0);
        applyStimulus(1'b0, 2'd2, 32'hFFFF_FF00, 32'h0);
        idle(8);

`ifdef SRAM_LIKE_MEM_ALIGN_CHECK_EN
        applyStimulus(1'b0, 2'd2, 32'h2, 32'h0);
        idle(6);
        applyStimulus(1'b1, 2'd1, 32'h25, 32'h5555AAAA);
        applyStimulus(1'b0, 2'd2, 32'h24, 32'h0);
        idle(6);
        doReset(2);
        idle(4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/sram_like_mem.md
Name: sram_like_mem

Overview:
- Parametrised SRAM-like slave memory model: successor to the fixed single-port ROM/RAM models behind the core's inst/data SRAM-like buses.
- Adds:
  - configurable depth
  - configurable response latency
  - multiple in-order outstanding requests
  - periodic addr_ok back-pressure
- One instance per bus (inst or data); benches preload and inspect the array `ram` hierarchically.

Parameters:
- ADDR_WIDTH, 12: word-index bits; depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1: cycles from acceptance to data_ok; legal 1..8.
- MAX_OUTSTANDING, 2: response queue depth; legal 1..8.
- STALL_PERIOD, 0: addr_ok forced low one cycle in every STALL_PERIOD cycles; 0 = never stall.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request valid.
- wr  input  1  1 = write, 0 = read.
- size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- addr  input  32  byte address; word index is addr[ADDR_WIDTH+1:2]; upper bits ignored (aliasing).
- wdata  input  32  write data, lane-aligned (byte at addr[1:0]=k sits in bits 8k+7:8k).
- rdata  output  32  full read word; valid only while data_ok=1.
- addr_ok  output  1  request accepted this cycle when req && addr_ok.
- data_ok  output  1  one-cycle response pulse, in request order.

Behaviour:
- Reset: data_ok=0, rdata=0, addr_ok=0 while rst=1.
  - Queue emptied; pending responses dropped and never delivered.
  - Stall counter cleared.
  - `ram` contents NOT reset; preload survives.
- Acceptance, combinational: addr_ok = !rst && !stall_now && (count < MAX_OUTSTANDING || retire_now).
  - Freeing by a retiring head in the same cycle counts as space.
  - addr_ok is driven regardless of req; acceptance is req && addr_ok.
- Write at the acceptance edge:
  - Byte enables from size/addr[1:0]: byte -> 1<<addr[1:0]; half -> 0011 or 1100 by addr[1]; word -> 1111.
  - Only enabled lanes of `ram` are updated.
- Read: full word sampled at acceptance and stored in the queue entry. Reads therefore see all earlier-accepted writes and never see later ones.
- Queue entry fields: {is_write, rdata, age}.
  - age starts at 1 on acceptance and increments each cycle, saturating at LATENCY.
- Retire:
  - Head with age == LATENCY retires: data_ok=1 and rdata = entry data (write responses drive rdata=0).
  - At most one retire per cycle.
  - An entry blocked behind the head keeps aging and retires on the cycle after the head.
- Latency: request accepted in cycle t gives data_ok in cycle t+LATENCY, provided no earlier response is pending.
- Throughput: MAX_OUTSTANDING >= LATENCY sustains one request per cycle.
- Simultaneous accept and retire in one cycle: count unchanged; both take effect.
- Stall: free-running counter 0..STALL_PERIOD-1; stall_now = (STALL_PERIOD != 0 && counter == STALL_PERIOD-1). Counter runs whether or not req is asserted.
- Full queue (count == MAX_OUTSTANDING, no retire this cycle): addr_ok=0; the requester must hold req and its fields.
- size=3 with the feature off: treated as word.

Optional Feature:
- Macro: SRAM_LIKE_MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, sticky, cleared only by rst).
  - Misaligned request = half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - A misaligned request still handshakes and still gets data_ok.
  - Its write is suppressed and its read returns 32'hDEADBEEF.
  - err rises the cycle after acceptance.
- Undefined: no err port; no checking; misaligned half/word use the byte enables above with addr[1:0] as given.

Decomposition:
- Package sram_like_pkg:
  - size_t enum: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
  - function byte_enable(size_t, logic[1:0]) -> logic[3:0].
  - resp_entry_t struct {is_write, data[31:0], age[3:0]}.
  - constant MISALIGN_DATA = 32'hDEADBEEF.
- Sub-module sram_like_resp_fifo:
  - circular buffer of resp_entry_t, parametrised by MAX_OUTSTANDING and LATENCY.
  - handles per-entry aging, head retire, count, and full/empty.

Test Plan:
- Preload ram[4]=32'h11223344, LATENCY=3, read addr 0x10 accepted in cycle t -> data_ok only in cycle t+3, rdata=32'h11223344.
- LATENCY=2, MAX_OUTSTANDING=2, back-to-back reads of 0x0/0x4/0x8 with req held -> three accepts in consecutive cycles, data_ok on three consecutive cycles in order.
- MAX_OUTSTANDING=1, LATENCY=4, two reads -> second addr_ok low for 3 cycles, rises in the head's retire cycle.
- Write byte 0x3 wdata=32'hAB000000 over ram[0]=0 -> ram[0]=32'hAB000000. Then write half 0x2 wdata=32'h12340000 -> ram[0]=32'h12340000, and a subsequent read returns it.
- STALL_PERIOD=4, req held high -> addr_ok pattern 1,1,1,0 repeating from reset release.
- Reset asserted with two responses pending -> no data_ok after reset, ram retains written data. With SRAM_LIKE_MEM_ALIGN_CHECK_EN, a word read at 0x2 -> rdata=32'hDEADBEEF, err=1 until rst.
